// File: rtl/ecc_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// ecc_scrub_ctrl
// Background scrubber for one ECC-protected memory. Walks addresses
// 0..DEPTH-1, reads each word through the shared (arbitrated) memory port,
// presents the captured word to an external combinational dual-checker, writes
// back corrected single-bit errors, and counts/logs uncorrectable and checker
// self-compare events.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   scrub_en, scrub_interval   enable and idle cycles between word scrubs
//   cnt_clr                    sync clear of counters and last_err_addr
//   mem_rd_*                   read request/grant, variable-latency return
//   ecc_*_in / ecc_* inputs    captured word to checker, checker results
//   mem_wr_*                   corrected write-back request/grant
//   sbit_cnt, dbit_cnt,
//   fault_cnt, last_err_addr   saturating statistics and error log
//   err_irq, pass_done         one-cycle event pulses
//   busy                       FSM not idle
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | scrubbing disabled, address pointer retained
// WAIT    | interval countdown between words
// RD_REQ  | read request held until granted
// RD_WAIT | waiting for read data valid, captures word on arrival
// CHECK   | single cycle evaluating checker outputs
// WR_REQ  | corrected write-back held until granted
// NEXT    | advance address, flag pass completion
// ----------------------------------------------------------------------------
module ecc_scrub_ctrl #(
   parameter int DATA_WIDTH   = 64,
   parameter int PARITY_WIDTH = 8,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1024,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    scrub_en,
   input  logic [15:0]             scrub_interval,
   input  logic                    cnt_clr,
   output logic                    mem_rd_req,
   output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
   input  logic                    mem_rd_gnt,
   input  logic                    mem_rd_vld,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
   output logic [DATA_WIDTH-1:0]   ecc_data_in,
   output logic [PARITY_WIDTH-1:0] ecc_parity_in,
   input  logic [DATA_WIDTH-1:0]   ecc_data_out,
   input  logic                    ecc_sbit_err,
   input  logic                    ecc_dbit_err,
   input  logic                    ecc_fault,
   output logic                    mem_wr_req,
   output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   input  logic                    mem_wr_gnt,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   output logic [ADDR_WIDTH-1:0]   last_err_addr,
   output logic                    err_irq,
   output logic                    pass_done,
   output logic                    busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_RD_REQ  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_CHECK   = 3'd4,
      S_WR_REQ  = 3'd5,
      S_NEXT    = 3'd6
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             ival_q, ival_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic [PARITY_WIDTH-1:0] rd_par_q, rd_par_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d;
   logic [CNT_WIDTH-1:0]    dbit_cnt_q, dbit_cnt_d;
   logic [CNT_WIDTH-1:0]    fault_cnt_q, fault_cnt_d;
   logic [ADDR_WIDTH-1:0]   last_err_q, last_err_d;
   logic                    err_irq_q, err_irq_d;
   logic                    pass_done_q, pass_done_d;
   logic                    sbit_inc, dbit_inc, fault_inc;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ival_d      = ival_q;
      rd_data_d   = rd_data_q;
      rd_par_d    = rd_par_q;
      wr_data_d   = wr_data_q;
      err_irq_d   = 1'b0;
      pass_done_d = 1'b0;
      sbit_inc    = 1'b0;
      dbit_inc    = 1'b0;
      fault_inc   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (scrub_en) begin
               if (scrub_interval == 16'd0) begin
                  state_d = S_RD_REQ;
               end else begin
                  state_d = S_WAIT;
                  ival_d  = scrub_interval;
               end
            end
         end
         S_WAIT: begin
            if (!scrub_en) begin
               state_d = S_IDLE;
            end else if (ival_q <= 16'd1) begin
               state_d = S_RD_REQ;
            end else begin
               ival_d = ival_q - 16'd1;
            end
         end
         S_RD_REQ: begin
            if (mem_rd_gnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_rd_vld) begin
               rd_data_d = mem_rd_data;
               rd_par_d  = mem_rd_parity;
               state_d   = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = S_NEXT;
            if (ecc_fault) begin
               fault_inc = 1'b1;
               err_irq_d = 1'b1;
            end else if (ecc_dbit_err) begin
               dbit_inc  = 1'b1;
               err_irq_d = 1'b1;
            end else if (ecc_sbit_err) begin
               sbit_inc  = 1'b1;
               wr_data_d = ecc_data_out;
               state_d   = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (mem_wr_gnt) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (addr_q == LAST_ADDR) begin
               addr_d      = '0;
               pass_done_d = 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
            // scrub_en is only sampled here once a word has started, so a
            // disable always lets the current word (and its write-back) finish
            if (!scrub_en) begin
               state_d = S_IDLE;
            end else if (scrub_interval == 16'd0) begin
               state_d = S_RD_REQ;
            end else begin
               state_d = S_WAIT;
               ival_d  = scrub_interval;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // clear has priority over any same-cycle increment
      sbit_cnt_d  = sbit_cnt_q;
      dbit_cnt_d  = dbit_cnt_q;
      fault_cnt_d = fault_cnt_q;
      last_err_d  = last_err_q;
      if (cnt_clr) begin
         sbit_cnt_d  = '0;
         dbit_cnt_d  = '0;
         fault_cnt_d = '0;
         last_err_d  = '0;
      end else begin
         if (sbit_inc && (sbit_cnt_q != CNT_MAX))   sbit_cnt_d  = sbit_cnt_q + 1'b1;
         if (dbit_inc && (dbit_cnt_q != CNT_MAX))   dbit_cnt_d  = dbit_cnt_q + 1'b1;
         if (fault_inc && (fault_cnt_q != CNT_MAX)) fault_cnt_d = fault_cnt_q + 1'b1;
         if (dbit_inc || fault_inc)                 last_err_d  = addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ival_q      <= '0;
         rd_data_q   <= '0;
         rd_par_q    <= '0;
         wr_data_q   <= '0;
         sbit_cnt_q  <= '0;
         dbit_cnt_q  <= '0;
         fault_cnt_q <= '0;
         last_err_q  <= '0;
         err_irq_q   <= 1'b0;
         pass_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ival_q      <= ival_d;
         rd_data_q   <= rd_data_d;
         rd_par_q    <= rd_par_d;
         wr_data_q   <= wr_data_d;
         sbit_cnt_q  <= sbit_cnt_d;
         dbit_cnt_q  <= dbit_cnt_d;
         fault_cnt_q <= fault_cnt_d;
         last_err_q  <= last_err_d;
         err_irq_q   <= err_irq_d;
         pass_done_q <= pass_done_d;
      end
   end

   assign mem_rd_req    = (state_q == S_RD_REQ);
   assign mem_rd_addr   = addr_q;
   assign ecc_data_in   = rd_data_q;
   assign ecc_parity_in = rd_par_q;
   assign mem_wr_req    = (state_q == S_WR_REQ);
   assign mem_wr_addr   = addr_q;
   assign mem_wr_data   = wr_data_q;
   assign sbit_cnt      = sbit_cnt_q;
   assign dbit_cnt      = dbit_cnt_q;
   assign fault_cnt     = fault_cnt_q;
   assign last_err_addr = last_err_q;
   assign err_irq       = err_irq_q;
   assign pass_done     = pass_done_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ecc_scrub_ctrl
// Bench for ecc_scrub_ctrl with a 4-word memory and 2-bit counters. A
// responder process plays arbiter, memory and event monitor; the ECC checker
// is modelled by error-type flags carried in the top three data bits plus a
// parity function. The reference model scrubs words in plain arithmetic.
// ----------------------------------------------------------------------------
module tb_ecc_scrub_ctrl;
   localparam int DW = 64, PW = 8, AW = 10, DEPTH = 4, CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk, rst_n, scrub_en, cnt_clr;
   logic [15:0]    scrub_interval;
   logic           mem_rd_req, mem_rd_gnt, mem_rd_vld;
   logic [AW-1:0]  mem_rd_addr, mem_wr_addr, last_err_addr;
   logic [DW-1:0]  mem_rd_data, ecc_data_in, ecc_data_out, mem_wr_data;
   logic [PW-1:0]  mem_rd_parity, ecc_parity_in;
   logic           ecc_sbit_err, ecc_dbit_err, ecc_fault;
   logic           mem_wr_req, mem_wr_gnt;
   logic [CW-1:0]  sbit_cnt, dbit_cnt, fault_cnt;
   logic           err_irq, pass_done, busy;

   ecc_scrub_ctrl #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .ADDR_WIDTH(AW),
                    .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
      .cnt_clr(cnt_clr), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_gnt(mem_rd_gnt), .mem_rd_vld(mem_rd_vld), .mem_rd_data(mem_rd_data),
      .mem_rd_parity(mem_rd_parity), .ecc_data_in(ecc_data_in), .ecc_parity_in(ecc_parity_in),
      .ecc_data_out(ecc_data_out), .ecc_sbit_err(ecc_sbit_err), .ecc_dbit_err(ecc_dbit_err),
      .ecc_fault(ecc_fault), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_gnt(mem_wr_gnt), .sbit_cnt(sbit_cnt),
      .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .last_err_addr(last_err_addr),
      .err_irq(err_irq), .pass_done(pass_done), .busy(busy));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] par_fn(input logic [63:0] d);
      return d[7:0] ^ d[15:8] ^ 8'h3C;
   endfunction

   // checker model: bit63 fault, bit62 dbit, bit61 sbit; bad parity is a fault
   assign ecc_fault    = ecc_data_in[63] | (ecc_parity_in != par_fn(ecc_data_in));
   assign ecc_dbit_err = ecc_data_in[62];
   assign ecc_sbit_err = ecc_data_in[61];
   assign ecc_data_out = {3'b000, ecc_data_in[60:0]};

   int checks = 0, failures = 0;
   logic [63:0] mem [DEPTH];
   int gnt_dly = 0, vld_dly = 1, wr_dly = 0;
   int clr_seq = 0, chk_clr_seq = 0;

   // written only by the responder
   int          rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$];
   logic [63:0] wr_data_q[$];
   int          irq_total = 0, pass_total = 0, stab_err = 0, cyc = 0;

   // reference model state
   int m_addr = 0, m_sbit = 0, m_dbit = 0, m_fault = 0, m_last = 0;

   initial begin
      int rcnt, wcnt, vcnt, raddr, clr_ack, chk_ack;
      bit pend, clr_next;
      logic [AW-1:0] hold_ra, hold_wa;
      logic [63:0]   hold_wd;
      rcnt = 0; wcnt = 0; vcnt = 0; raddr = 0; clr_ack = 0; chk_ack = 0;
      pend = 0; clr_next = 0; hold_ra = '0; hold_wa = '0; hold_wd = '0;
      mem_rd_gnt = 0; mem_rd_vld = 0; mem_wr_gnt = 0; cnt_clr = 0;
      mem_rd_data = '0; mem_rd_parity = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (err_irq === 1'b1) irq_total++;
         if (pass_done === 1'b1) pass_total++;
         cnt_clr = 1'b0;
         if (clr_next) begin cnt_clr = 1'b1; clr_next = 0; end
         if (clr_seq != clr_ack) begin cnt_clr = 1'b1; clr_ack = clr_seq; end
         if (!rst_n) begin
            pend = 0; rcnt = 0; wcnt = 0;
            mem_rd_gnt = 0; mem_rd_vld = 0; mem_wr_gnt = 0;
            continue;
         end
         mem_rd_vld = 1'b0;
         if (pend) begin
            vcnt--;
            if (vcnt <= 0) begin
               mem_rd_vld    = 1'b1;
               mem_rd_data   = mem[raddr];
               mem_rd_parity = par_fn(mem[raddr]);
               pend = 0;
               if (chk_clr_seq != chk_ack) begin clr_next = 1; chk_ack = chk_clr_seq; end
            end
         end else if ($urandom_range(0, 3) == 0) begin
            // stray valid with a poisoned word; must never be captured
            mem_rd_vld    = 1'b1;
            mem_rd_data   = {3'b111, 29'h0, 32'($urandom)};
            mem_rd_parity = 8'($urandom);
         end
         if (mem_rd_req === 1'b1) begin
            if (rcnt == 0) hold_ra = mem_rd_addr;
            else if (mem_rd_addr !== hold_ra) stab_err++;
            if (rcnt >= gnt_dly) begin
               mem_rd_gnt = 1'b1;
               rd_addr_q.push_back(int'(mem_rd_addr));
               rd_cyc_q.push_back(cyc);
               pend = 1; vcnt = vld_dly; raddr = int'(mem_rd_addr) % DEPTH; rcnt = 0;
            end else begin
               mem_rd_gnt = 1'b0; rcnt++;
            end
         end else begin
            mem_rd_gnt = 1'b0; rcnt = 0;
         end
         if (mem_wr_req === 1'b1) begin
            if (wcnt == 0) begin hold_wa = mem_wr_addr; hold_wd = mem_wr_data; end
            else if (mem_wr_addr !== hold_wa || mem_wr_data !== hold_wd) stab_err++;
            if (wcnt >= wr_dly) begin
               mem_wr_gnt = 1'b1;
               wr_addr_q.push_back(int'(mem_wr_addr));
               wr_data_q.push_back(mem_wr_data);
               wcnt = 0;
            end else begin
               mem_wr_gnt = 1'b0; wcnt++;
            end
         end else begin
            mem_wr_gnt = 1'b0; wcnt = 0;
         end
      end
   end

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic set_word(input int a, input int kind);
      logic [63:0] p;
      p = {$urandom, $urandom};
      mem[a] = {3'(kind), p[60:0]};
   endtask

   task automatic clean_all();
      for (int a = 0; a < DEPTH; a++) set_word(a, 0);
   endtask

   task automatic do_clear();
      clr_seq++;
      repeat (3) @(posedge clk);
      #2;
      m_sbit = 0; m_dbit = 0; m_fault = 0; m_last = 0;
   endtask

   // scrub n words (or one word, disabled while its write-back is pending)
   // and compare everything observed against the model
   task automatic run_words(input int n, input int interval, input int period,
                            input bit stop_on_wr, input bit clr_at_chk, input string nm);
      int exp_rd[$], exp_wa[$];
      logic [63:0] exp_wd[$];
      int exp_irq, exp_pass, r0, w0, i0, p0, s0, budget;
      bit done;
      exp_irq = 0; exp_pass = 0;
      r0 = rd_addr_q.size(); w0 = wr_addr_q.size();
      i0 = irq_total; p0 = pass_total; s0 = stab_err;
      for (int k = 0; k < n; k++) begin
         int a;
         logic [63:0] w;
         a = m_addr; w = mem[a];
         exp_rd.push_back(a);
         if (w[63]) begin m_fault = sat(m_fault + 1); m_last = a; exp_irq++; end
         else if (w[62]) begin m_dbit = sat(m_dbit + 1); m_last = a; exp_irq++; end
         else if (w[61]) begin
            m_sbit = sat(m_sbit + 1);
            exp_wa.push_back(a);
            exp_wd.push_back({3'b000, w[60:0]});
         end
         if (a == DEPTH - 1) exp_pass++;
         m_addr = (a + 1) % DEPTH;
      end
      if (clr_at_chk) begin
         m_sbit = 0; m_dbit = 0; m_fault = 0; m_last = 0;
         chk_clr_seq++;
      end
      @(posedge clk); #2;
      scrub_interval = 16'(interval);
      scrub_en = 1'b1;
      done = 0; budget = 0;
      while (!done && budget < 3000) begin
         @(posedge clk); #2;
         budget++;
         done = stop_on_wr ? (mem_wr_req === 1'b1) : (rd_addr_q.size() >= r0 + n);
      end
      checks++;
      if (!done) begin failures++; $display("FAIL %s/start: timed out waiting for scrub activity", nm); end
      if (stop_on_wr) begin
         checks++;
         if (wr_addr_q.size() != w0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s/wr_pending: writes=%0d busy=%b, required 0 writes and busy=1", nm, wr_addr_q.size() - w0, busy);
         end
      end
      scrub_en = 1'b0;
      budget = 0;
      while (busy !== 1'b0 && budget < 3000) begin @(posedge clk); #2; budget++; end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
         failures++; $display("FAIL %s/idle: busy=%b rd_req=%b wr_req=%b, required all 0", nm, busy, mem_rd_req, mem_wr_req);
      end
      checks++;
      if (rd_addr_q.size() - r0 != n) begin
         failures++; $display("FAIL %s/rd_count: got %0d required %0d", nm, rd_addr_q.size() - r0, n);
      end
      for (int k = 0; k < n && r0 + k < rd_addr_q.size(); k++) begin
         checks++;
         if (rd_addr_q[r0 + k] != exp_rd[k]) begin
            failures++; $display("FAIL %s/rd_addr[%0d]: got %0d required %0d", nm, k, rd_addr_q[r0 + k], exp_rd[k]);
         end
      end
      checks++;
      if (wr_addr_q.size() - w0 != exp_wa.size()) begin
         failures++; $display("FAIL %s/wr_count: got %0d required %0d", nm, wr_addr_q.size() - w0, exp_wa.size());
      end
      for (int k = 0; k < exp_wa.size() && w0 + k < wr_addr_q.size(); k++) begin
         checks++;
         if (wr_addr_q[w0 + k] != exp_wa[k] || wr_data_q[w0 + k] !== exp_wd[k]) begin
            failures++;
            $display("FAIL %s/wr[%0d]: got addr %0d data %h required addr %0d data %h", nm, k,
                     wr_addr_q[w0 + k], wr_data_q[w0 + k], exp_wa[k], exp_wd[k]);
         end
      end
      if (period > 0) begin
         for (int k = 1; k < n && r0 + k < rd_cyc_q.size(); k++) begin
            checks++;
            if (rd_cyc_q[r0 + k] - rd_cyc_q[r0 + k - 1] != period) begin
               failures++; $display("FAIL %s/period[%0d]: got %0d cycles required %0d", nm, k,
                                    rd_cyc_q[r0 + k] - rd_cyc_q[r0 + k - 1], period);
            end
         end
      end
      checks++;
      if (irq_total - i0 != exp_irq) begin
         failures++; $display("FAIL %s/err_irq: got %0d pulses required %0d", nm, irq_total - i0, exp_irq);
      end
      checks++;
      if (pass_total - p0 != exp_pass) begin
         failures++; $display("FAIL %s/pass_done: got %0d pulses required %0d", nm, pass_total - p0, exp_pass);
      end
      checks++;
      if (int'(sbit_cnt) != m_sbit || int'(dbit_cnt) != m_dbit || int'(fault_cnt) != m_fault) begin
         failures++; $display("FAIL %s/counts: got s=%0d d=%0d f=%0d required s=%0d d=%0d f=%0d", nm,
                              sbit_cnt, dbit_cnt, fault_cnt, m_sbit, m_dbit, m_fault);
      end
      checks++;
      if (int'(last_err_addr) != m_last) begin
         failures++; $display("FAIL %s/last_err_addr: got %0d required %0d", nm, last_err_addr, m_last);
      end
      checks++;
      if (stab_err != s0) begin
         failures++; $display("FAIL %s/req_stable: got %0d changes while requesting required 0", nm, stab_err - s0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; scrub_en = 1'b0; scrub_interval = '0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({mem_rd_req, mem_wr_req, err_irq, pass_done, busy} !== 5'b0) begin
         failures++; $display("FAIL reset/strobes: got %b required 00000", {mem_rd_req, mem_wr_req, err_irq, pass_done, busy});
      end
      checks++;
      if ({mem_rd_addr, mem_wr_addr, last_err_addr} !== '0) begin
         failures++; $display("FAIL reset/addrs: got %h required 0", {mem_rd_addr, mem_wr_addr, last_err_addr});
      end
      checks++;
      if ({ecc_data_in, ecc_parity_in, mem_wr_data} !== '0) begin
         failures++; $display("FAIL reset/data: got %h required 0", {ecc_data_in, ecc_parity_in, mem_wr_data});
      end
      checks++;
      if ({sbit_cnt, dbit_cnt, fault_cnt} !== '0) begin
         failures++; $display("FAIL reset/counts: got %h required 0", {sbit_cnt, dbit_cnt, fault_cnt});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic test_clean_pass();
      clean_all();
      gnt_dly = 0; vld_dly = 1; wr_dly = 0;
      run_words(4, 0, 4, 0, 0, "clean_pass");
   endtask

   task automatic test_sbit_writeback();
      clean_all();
      mem[2] = {3'b001, 61'hA5A5};
      wr_dly = 3;
      run_words(4, 0, 0, 0, 0, "sbit_wb");
      checks++;
      if (wr_data_q.size() == 0 || wr_data_q[wr_data_q.size() - 1] !== 64'hA5A5) begin
         failures++; $display("FAIL sbit_wb/data_const: got %0d writes, required last data 000000000000a5a5", wr_data_q.size());
      end
   endtask

   task automatic test_dbit_fault();
      clean_all();
      do_clear();
      checks++;
      if ({sbit_cnt, dbit_cnt, fault_cnt, last_err_addr} !== '0) begin
         failures++; $display("FAIL clear/counts: got %h required 0", {sbit_cnt, dbit_cnt, fault_cnt, last_err_addr});
      end
      set_word(1, 3'b010);
      set_word(3, 3'b101);
      wr_dly = 0;
      run_words(4, 0, 0, 0, 0, "dbit_fault");
      checks++;
      if (dbit_cnt !== 2'd1 || fault_cnt !== 2'd1 || last_err_addr !== 10'd3) begin
         failures++; $display("FAIL dbit_fault/const: got d=%0d f=%0d last=%0d required d=1 f=1 last=3",
                              dbit_cnt, fault_cnt, last_err_addr);
      end
   endtask

   task automatic test_handshake_delays();
      clean_all();
      gnt_dly = 5; vld_dly = 3;
      run_words(3, 3, 14, 0, 0, "slow_handshake");
      gnt_dly = 0; vld_dly = 1;
   endtask

   task automatic test_disable_in_write();
      int prev;
      clean_all();
      prev = m_addr;
      set_word(prev, 3'b001);
      wr_dly = 4;
      run_words(1, 0, 0, 1, 0, "disable_wr");
      wr_dly = 0;
      run_words(1, 0, 0, 0, 0, "resume");
      checks++;
      if (rd_addr_q[rd_addr_q.size() - 1] != (prev + 1) % DEPTH) begin
         failures++; $display("FAIL resume/addr: got %0d required %0d", rd_addr_q[rd_addr_q.size() - 1], (prev + 1) % DEPTH);
      end
   endtask

   task automatic test_saturation();
      do_clear();
      for (int a = 0; a < DEPTH; a++) set_word(a, 3'b001);
      run_words(5, 0, 0, 0, 0, "saturate");
      checks++;
      if (sbit_cnt !== 2'd3) begin
         failures++; $display("FAIL saturate/const: got %0d required 3", sbit_cnt);
      end
      run_words(1, 0, 0, 0, 1, "clr_vs_inc");
      checks++;
      if (sbit_cnt !== 2'd0) begin
         failures++; $display("FAIL clr_vs_inc/const: got %0d required 0", sbit_cnt);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < DEPTH; a++) set_word(a, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7)));
         gnt_dly = int'($urandom_range(0, 3));
         vld_dly = int'($urandom_range(1, 4));
         wr_dly  = int'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) do_clear();
         run_words(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 0, 0, 0, $sformatf("rand%0d", it));
      end
      gnt_dly = 0; vld_dly = 1; wr_dly = 0;
   endtask

   task automatic test_async_reset();
      int r0, budget;
      clean_all();
      vld_dly = 30;
      r0 = rd_addr_q.size();
      @(posedge clk); #2;
      scrub_interval = 16'd0;
      scrub_en = 1'b1;
      budget = 0;
      while (rd_addr_q.size() == r0 && budget < 200) begin @(posedge clk); #2; budget++; end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL async_rst/pre_busy: got %b required 1", busy);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_rd_req, mem_wr_req, err_irq, pass_done, busy} !== 5'b0) begin
         failures++; $display("FAIL async_rst/strobes: got %b required 00000", {mem_rd_req, mem_wr_req, err_irq, pass_done, busy});
      end
      checks++;
      if ({mem_rd_addr, mem_wr_addr, last_err_addr, sbit_cnt, dbit_cnt, fault_cnt} !== '0) begin
         failures++; $display("FAIL async_rst/state: got %h required 0",
                              {mem_rd_addr, mem_wr_addr, last_err_addr, sbit_cnt, dbit_cnt, fault_cnt});
      end
      checks++;
      if ({ecc_data_in, ecc_parity_in, mem_wr_data} !== '0) begin
         failures++; $display("FAIL async_rst/data: got %h required 0", {ecc_data_in, ecc_parity_in, mem_wr_data});
      end
      scrub_en = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      vld_dly = 1;
      m_addr = 0; m_sbit = 0; m_dbit = 0; m_fault = 0; m_last = 0;
      repeat (2) @(posedge clk);
      #2;
      run_words(2, 0, 4, 0, 0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_clean_pass();
      test_sbit_writeback();
      test_dbit_fault();
      test_handshake_delays();
      test_disable_in_write();
      test_saturation();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
